// File: rtl/psd_acc_pkg.sv
// Shared types and helpers for the power-spectrum accumulator.
// sat_add is only referenced when PSD_ACC_SAT_EN is defined.
package psd_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACC   = 2'd2,
    DRAIN = 2'd3
  } acc_state_e;

  localparam int SAT_MAX_W = 128;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Unsigned add clamped to the largest value representable in w bits (w < SAT_MAX_W)
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int w);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
    return (sum > limit) ? limit[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/psd_acc_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset,
// so synthesis can map it onto block RAM.
module psd_acc_dpram #(
  parameter int W     = 64,
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/psd_accumulator.sv
// Sums n_pulses spectra (NBINS x NGATES) in RAM by read-modify-write, then drains them.
// Define PSD_ACC_SAT_EN to clamp overflowing sums instead of wrapping.
module psd_accumulator
  import psd_acc_pkg::*;
#(
  parameter int DIN_W    = 50,
  parameter int ACC_W    = 64,
  parameter int NBINS    = 512,
  parameter int NGATES   = 16,
  parameter int NPULSE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NPULSE_W-1:0] n_pulses,
  input  logic [DIN_W-1:0]    din,
  input  logic                din_valid,
  input  logic                din_sof,
  output logic [ACC_W-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic                done,
  output logic                frame_err,
  output logic                ovf
);

  localparam int DEPTH = NBINS * NGATES;
  localparam int AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  acc_state_e state;
  logic [AW-1:0] addr;
  logic [NPULSE_W-1:0] pulse_cnt, pulse_nxt, n_eff;
  logic acc_done;

  logic accept, resync, first_pulse, acc_rd;
  logic [AW-1:0] s0_addr;

  logic s1_valid, s1_first, s1_fwd_hit;
  logic [AW-1:0] s1_addr;
  logic [DIN_W-1:0] s1_din;
  logic [ACC_W-1:0] s1_fwd_data, s1_op;

  logic s2_valid, s2_first, carry;
  logic [AW-1:0] s2_addr;
  logic [DIN_W-1:0] s2_din;
  logic [ACC_W-1:0] s2_op, acc_sum, wr_data;
  logic [ACC_W:0] sum_ext;

  logic [AW-1:0] drain_addr, beat_cnt, rd_addr;
  logic rd_all, rd_pend, drain_rd, pop, skid_valid;
  logic [ACC_W-1:0] skid, rd_data;
  logic [1:0] occ_after;

  assign busy = (state == ACC) || (state == DRAIN);
  assign first_pulse = (pulse_cnt == '0);
  assign pulse_nxt = pulse_cnt + 1'b1;

  // Stage 0: a sync mark anywhere but address 0 restarts the pulse at address 0
  always_comb begin
    accept = 1'b0;
    if (din_valid) begin
      if (state == ARM) accept = din_sof;
      else if (state == ACC && !acc_done) accept = 1'b1;
    end
    resync  = accept && (state == ACC) && din_sof && (addr != '0);
    s0_addr = ((state == ARM) || din_sof) ? '0 : addr;
  end

  assign acc_rd = accept && !first_pulse;

  // Newest write wins: the one in stage 2 now, then the one that overlapped the read
  assign s1_op = (s2_valid && (s2_addr == s1_addr)) ? wr_data :
                 s1_fwd_hit ? s1_fwd_data : rd_data;

  assign sum_ext = {1'b0, s2_op} + (ACC_W+1)'(s2_din);
  assign carry   = sum_ext[ACC_W] && !s2_first;

`ifdef PSD_ACC_SAT_EN
  assign acc_sum = ACC_W'(sat_add(SAT_MAX_W'(s2_op), SAT_MAX_W'(s2_din), ACC_W));
`else
  assign acc_sum = sum_ext[ACC_W-1:0];
`endif

  assign wr_data = s2_first ? ACC_W'(s2_din) : acc_sum;

  // Drain reads are issued only when the two-entry output buffer is sure to have room
  assign pop = dout_valid && dout_ready;
  assign occ_after = 2'(dout_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
  assign drain_rd = (state == DRAIN) && !rd_all && (occ_after <= 2'd1);
  assign rd_addr = (state == DRAIN) ? drain_addr : s0_addr;

  psd_acc_dpram #(.W(ACC_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (s2_valid),
    .waddr (s2_addr),
    .wdata (wr_data),
    .re    (acc_rd || drain_rd),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      pulse_cnt  <= '0;
      n_eff      <= NPULSE_W'(1);
      acc_done   <= 1'b0;
      frame_err  <= 1'b0;
      drain_addr <= '0;
      beat_cnt   <= '0;
      rd_all     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (resync) frame_err <= 1'b1;
        if (s0_addr == LAST_ADDR) begin
          addr      <= '0;
          pulse_cnt <= pulse_nxt;
          if (pulse_nxt == n_eff) acc_done <= 1'b1;
        end else begin
          addr <= s0_addr + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            n_eff     <= (n_pulses == '0) ? NPULSE_W'(1) : n_pulses;
            pulse_cnt <= '0;
            addr      <= '0;
            acc_done  <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        ARM: begin
          if (accept) state <= ACC;
        end
        ACC: begin
          // Leave only once the last write has reached the RAM
          if (acc_done && !s1_valid && !s2_valid) begin
            state      <= DRAIN;
            drain_addr <= '0;
            beat_cnt   <= '0;
            rd_all     <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_rd) begin
            if (drain_addr == LAST_ADDR) rd_all <= 1'b1;
            else drain_addr <= drain_addr + 1'b1;
          end
          if (pop) begin
            if (beat_cnt == LAST_ADDR) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_addr     <= '0;
      s1_din      <= '0;
      s1_fwd_hit  <= 1'b0;
      s1_fwd_data <= '0;
      s2_valid    <= 1'b0;
      s2_first    <= 1'b0;
      s2_addr     <= '0;
      s2_din      <= '0;
      s2_op       <= '0;
      ovf         <= 1'b0;
    end else begin
      s1_valid    <= accept;
      s1_first    <= first_pulse;
      s1_addr     <= s0_addr;
      s1_din      <= din;
      s1_fwd_hit  <= s2_valid && (s2_addr == s0_addr);
      s1_fwd_data <= wr_data;
      s2_valid    <= s1_valid;
      s2_first    <= s1_first;
      s2_addr     <= s1_addr;
      s2_din      <= s1_din;
      s2_op       <= s1_op;
      if (state == IDLE && start) ovf <= 1'b0;
      else if (s2_valid && carry) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      skid       <= '0;
      skid_valid <= 1'b0;
    end else begin
      rd_pend <= drain_rd;
      if (rd_pend && pop) begin
        if (skid_valid) begin
          dout <= skid;
          skid <= rd_data;
        end else begin
          dout <= rd_data;
        end
      end else if (rd_pend) begin
        if (!dout_valid) begin
          dout       <= rd_data;
          dout_valid <= 1'b1;
        end else begin
          skid       <= rd_data;
          skid_valid <= 1'b1;
        end
      end else if (pop) begin
        if (skid_valid) begin
          dout       <= skid;
          skid_valid <= 1'b0;
        end else begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_psd_accumulator.sv
// Directed bench for psd_accumulator with NBINS=4, NGATES=2, DIN_W=8, ACC_W=10.
// Overflow expectations follow PSD_ACC_SAT_EN when the bench is built with it.
module tb_psd_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_pulses = '0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_sof = 1'b0;
  logic [9:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy, done, frame_err, ovf;

  int checks = 0;
  int failures = 0;

  psd_accumulator #(
    .DIN_W(8), .ACC_W(10), .NBINS(4), .NGATES(2), .NPULSE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_pulses(n_pulses),
    .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dinVal(input int mode, input int a);
    case (mode)
      0: return a + 1;
      1: return 255;
      2: return (a * 37 + 5) & 255;
      default: return 0;
    endcase
  endfunction

  // 0: three pulses of addr+1; 1: eight pulses of 255; 2: one pulse of the mode-2 pattern
  function automatic int expVal(input int mode, input int a);
    case (mode)
      0: return 3 * (a + 1);
`ifdef PSD_ACC_SAT_EN
      1: return 1023;
`else
      1: return 1016;
`endif
      default: return dinVal(2, a);
    endcase
  endfunction

  task automatic sendSample(input int d, input bit sof, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    din       = 8'(d);
    din_sof   = sof;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic startRun(input int n);
    n_pulses = 16'(n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic applyStimulus(input int mode, input int npulses, input bit gaps);
    for (int p = 0; p < npulses; p++)
      for (int a = 0; a < 8; a++)
        sendSample(dinVal(mode, a), a == 0, gaps);
  endtask

  task automatic collectDrain(input int mode, input bit rand_ready, input bit poke_start,
                              input string tag);
    int beat = 0;
    int cycles = 0;
    int early_done = 0;
    bit stalled = 1'b0;
    logic [9:0] held = '0;
    while (beat < 8 && cycles < 400) begin
      if (done) early_done++;
      if (stalled) checkOutput({tag, "_stall_hold"}, {dout_valid, dout}, {1'b1, held});
      stalled    = 1'b0;
      dout_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      start      = poke_start && (beat == 2);
      if (dout_valid) begin
        if (dout_ready) begin
          checkOutput($sformatf("%s_beat%0d", tag, beat), dout, expVal(mode, beat));
          beat++;
        end else begin
          stalled = 1'b1;
          held    = dout;
        end
      end
      tick();
      cycles++;
      start = 1'b0;
    end
    dout_ready = 1'b0;
    if (beat < 8) checkOutput({tag, "_timeout_beats"}, beat, 8);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_low"}, busy, 0);
    checkOutput({tag, "_early_done"}, early_done, 0);
    tick();
    checkOutput({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) tick();
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_dout_valid", dout_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    $display("[TB] contiguous run, n_pulses=3");
    startRun(3);
    checkOutput("arm_not_busy", busy, 0);
    applyStimulus(0, 3, 1'b0);
    collectDrain(0, 1'b0, 1'b0, "basic");
    checkOutput("basic_frame_err", frame_err, 0);
    checkOutput("basic_ovf", ovf, 0);

    $display("[TB] input gaps and random backpressure");
    startRun(3);
    applyStimulus(0, 3, 1'b1);
    collectDrain(0, 1'b1, 1'b0, "gaps");

    // The abandoned partial pulse carries zero power, so totals stay at 3x
    $display("[TB] sync mark at address 5 during the second pulse");
    startRun(3);
    applyStimulus(0, 1, 1'b0);
    for (int a = 0; a < 5; a++) sendSample(0, a == 0, 1'b0);
    applyStimulus(0, 2, 1'b0);
    collectDrain(0, 1'b0, 1'b0, "resync");
    checkOutput("resync_frame_err", frame_err, 1);

    $display("[TB] overflow, n_pulses=8 of 255");
    startRun(8);
    applyStimulus(1, 8, 1'b0);
    collectDrain(1, 1'b1, 1'b0, "ovf");
    checkOutput("ovf_flag", ovf, 1);
    checkOutput("ovf_frame_err_cleared", frame_err, 0);

    $display("[TB] reset in the middle of accumulation");
    startRun(3);
    applyStimulus(0, 1, 1'b0);
    sendSample(7, 1'b1, 1'b0);
    sendSample(7, 1'b0, 1'b0);
    sendSample(7, 1'b1, 1'b0);
    checkOutput("mid_acc_busy", busy, 1);
    checkOutput("mid_acc_frame_err", frame_err, 1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_frame_err", frame_err, 0);
    checkOutput("mid_rst_dout_valid", dout_valid, 0);
    rst = 1'b0;
    tick();
    startRun(1);
    applyStimulus(2, 1, 1'b0);
    collectDrain(2, 1'b0, 1'b0, "after_rst");
    checkOutput("after_rst_frame_err", frame_err, 0);
    checkOutput("after_rst_ovf", ovf, 0);

    $display("[TB] n_pulses=0 and start during drain");
    startRun(0);
    applyStimulus(2, 1, 1'b0);
    collectDrain(2, 1'b0, 1'b1, "np0");
    sendSample(9, 1'b1, 1'b0);
    checkOutput("start_in_drain_ignored", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
